alarm_bank: RTL and testbench

Parametrised multi-channel alarm unit replacing the fixed two-alarm datapath. It holds NUM_ALARMS programmable HH:MM alarms, compares them against the running 24-bit BCD time once per second, and arbitrates simultaneous hits. It drives a single ring request with channel index, and supports snooze, stop and ring timeout. It sits between the clock counter (clock_data, 1 Hz flag) and the buzzer driver and display mux.

---
 rtl/alarm_bank_if.sv | 33 +++
 rtl/alarm_bank.sv | 191 +++++++++++++++++++
 tb/tb_alarm_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_if.sv
// Register-file access bus for alarm_bank.
// Ports (signals):
//   wr_en      one-cycle write strobe
//   wr_idx     channel written
//   wr_time    BCD HHMM written
//   wr_enable  channel enable written with wr_time
//   rd_idx     channel read
//   rd_time    stored HHMM of rd_idx
//   rd_enable  stored enable of rd_idx
// master drives writes and the read index; slave (alarm_bank) returns read data.
interface alarm_bank_if #(
  parameter int unsigned NUM_ALARMS = 4
);
  localparam int unsigned IW = $clog2(NUM_ALARMS);

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [15:0]   wr_time;
  logic          wr_enable;
  logic [IW-1:0] rd_idx;
  logic [15:0]   rd_time;
  logic          rd_enable;

  modport master (
    output wr_en, wr_idx, wr_time, wr_enable, rd_idx,
    input  rd_time, rd_enable
  );

  modport slave (
    input  wr_en, wr_idx, wr_time, wr_enable, rd_idx,
    output rd_time, rd_enable
  );
endinterface

// File: rtl/alarm_bank.sv
// Multi-channel HH:MM alarm unit. Compares every enabled channel against the
// running BCD time once per second, latches hits into pending, and serves them
// lowest index first through a single ring request with snooze/stop/timeout.
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   clock_data          BCD HHMMSS time
//   flag                1 Hz tick, one cycle wide
//   bus                 register-file write/read bus (slave side)
//   snooze, stop        one-cycle key pulses
//   ring, ring_idx      buzzer request and channel being served
//   snoozing            high while the active channel is snoozed
//   pending             triggered-but-unserved channels, including the active one
module alarm_bank #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  localparam int unsigned IW        = $clog2(NUM_ALARMS)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [23:0]           clock_data,
  input  logic                  flag,
  alarm_bank_if.slave           bus,
  input  logic                  snooze,
  input  logic                  stop,
  output logic                  ring,
  output logic [IW-1:0]         ring_idx,
  output logic                  snoozing,
  output logic [NUM_ALARMS-1:0] pending
);

  localparam logic [7:0]  RingLast   = 8'(RING_SEC - 1);
  localparam logic [10:0] SnoozeLoad = 11'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {StIdle, StRinging, StSnooze} state_e;

  state_e                state_q, state_d;
  logic [15:0]           time_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;
  logic                  tick_q;
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            ring_cnt_q, ring_cnt_d;
  logic [10:0]           snz_cnt_q, snz_cnt_d;
  logic [NUM_ALARMS-1:0] wr_mask;
  logic [NUM_ALARMS-1:0] hit;
  logic [NUM_ALARMS-1:0] avail;
  logic                  low_found;
  logic [IW-1:0]         low_idx;
  logic                  active_wr;
  logic                  serve_clr;

  // Decoded write strobe and per-channel match on the delayed tick.
  always_comb begin
    wr_mask = '0;
    hit     = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      wr_mask[i] = bus.wr_en && (bus.wr_idx == IW'(i));
      hit[i]     = tick_q && en_q[i] && (time_q[i] == clock_data[23:8]) &&
                   (clock_data[7:0] == 8'h00);
    end
  end

  // Combinational readback.
  always_comb begin
    bus.rd_time   = '0;
    bus.rd_enable = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (bus.rd_idx == IW'(i)) begin
        bus.rd_time   = time_q[i];
        bus.rd_enable = en_q[i];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) time_q[i] <= '0;
      en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_mask[i]) begin
          time_q[i] <= bus.wr_time;
          en_q[i]   <= bus.wr_enable;
        end
      end
    end
  end

  // A channel being rewritten this cycle is not a candidate for service.
  assign avail = pending_q & ~wr_mask;

  // Lowest set index: scan downward so the last assignment is the lowest.
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        low_found = 1'b1;
        low_idx   = IW'(i);
      end
    end
  end

  assign active_wr = wr_mask[idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    serve_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (low_found) begin
          state_d    = StRinging;
          idx_d      = low_idx;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
        end
      end
      StRinging: begin
        if (active_wr) begin
          state_d = StIdle;
        end else if (stop) begin
          serve_clr = 1'b1;
          state_d   = StIdle;
        end else if (snooze) begin
          snz_cnt_d = SnoozeLoad;
          state_d   = StSnooze;
        end else if (tick_q) begin
          if (ring_cnt_q >= RingLast) begin
            serve_clr  = 1'b1;
            ring_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
      end
      StSnooze: begin
        if (active_wr) begin
          state_d = StIdle;
        end else if (stop) begin
          serve_clr = 1'b1;
          state_d   = StIdle;
        end else if (tick_q) begin
          // The tick that would take the counter to zero ends the snooze.
          if (snz_cnt_q <= 11'd1) begin
            snz_cnt_d  = '0;
            ring_cnt_d = '0;
            state_d    = StRinging;
          end else begin
            snz_cnt_d = snz_cnt_q - 11'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Writes override both a same-cycle match and service.
  always_comb begin
    pending_d = (pending_q | hit) & ~wr_mask;
    if (serve_clr) pending_d[idx_q] = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      tick_q     <= 1'b0;
      pending_q  <= '0;
      idx_q      <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= flag;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign ring     = (state_q == StRinging);
  assign snoozing = (state_q == StSnooze);
  assign ring_idx = idx_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [23:0] clock_data = '0;
  logic        flag = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic        ring;
  logic [1:0]  ring_idx;
  logic        snoozing;
  logic [3:0]  pending;

  alarm_bank_if #(.NUM_ALARMS(4)) bus ();

  alarm_bank #(
    .NUM_ALARMS(4),
    .RING_SEC  (60),
    .SNOOZE_MIN(5)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clock_data(clock_data),
    .flag      (flag),
    .bus       (bus),
    .snooze    (snooze),
    .stop      (stop),
    .ring      (ring),
    .ring_idx  (ring_idx),
    .snoozing  (snoozing),
    .pending   (pending)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // idx / rd of -1 mean "don't care".
  typedef struct {
    int unsigned at;
    string       name;
    logic        ring;
    int          idx;
    logic        snz;
    logic [3:0]  pend;
    int          rd;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic expect_at(input int unsigned ofs, input string name, input logic r,
                           input int idx, input logic s, input logic [3:0] p,
                           input int rd = -1);
    exp_t e;
    e.at = cyc + ofs; e.name = name; e.ring = r; e.idx = idx;
    e.snz = s; e.pend = p; e.rd = rd;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due at this cycle.
  exp_t me;
  logic ok;
  always @(negedge sys_clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      me = sb.pop_front();
      n_chk++;
      if (me.at < cyc) begin
        $display("FAIL %s: not sampled at cycle %0d (now %0d)", me.name, me.at, cyc);
      end else begin
        ok = (ring === me.ring) && (snoozing === me.snz) && (pending === me.pend) &&
             (me.idx < 0 || ring_idx === 2'(me.idx)) &&
             (me.rd < 0 || bus.rd_enable === 1'(me.rd));
        if (ok) n_pass++;
        else $display("FAIL %s: got ring=%b idx=%0d snoozing=%b pending=%b rd_enable=%b, want ring=%b idx=%0d snoozing=%b pending=%b rd_enable=%0d",
                      me.name, ring, ring_idx, snoozing, pending, bus.rd_enable,
                      me.ring, me.idx, me.snz, me.pend, me.rd);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wr(input int idx, input logic [15:0] t, input logic en);
    bus.wr_en = 1'b1; bus.wr_idx = 2'(idx); bus.wr_time = t; bus.wr_enable = en;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic tick(input logic [23:0] d);
    clock_data = d; flag = 1'b1;
    step();
    flag = 1'b0;
    step();
  endtask

  task automatic fill(input int n);
    repeat (n) tick(24'h123401);
  endtask

  task automatic pulse(input logic do_stop, input logic do_snooze);
    stop = do_stop; snooze = do_snooze;
    step();
    stop = 1'b0; snooze = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_time = '0; bus.wr_enable = 1'b0;
    bus.rd_idx = '0;
    step(2);
    expect_at(0, "reset_state", 1'b0, 0, 1'b0, 4'b0000, 0);
    sys_rst_n = 1'b1;
    step(2);

    // Single channel, auto-stop after 60 ticks.
    wr(1, 16'h0730, 1'b1);
    tick(24'h072959);
    expect_at(2, "t1_pend", 1'b0, -1, 1'b0, 4'b0010);
    expect_at(3, "t1_ring", 1'b1, 1, 1'b0, 4'b0010);
    tick(24'h073000);
    fill(59);
    expect_at(1, "t1_ring_last", 1'b1, 1, 1'b0, 4'b0010);
    expect_at(2, "t1_autostop", 1'b0, -1, 1'b0, 4'b0000);
    tick(24'h123401);
    step();

    // Two simultaneous hits, lowest index first.
    wr(0, 16'h0600, 1'b1);
    wr(2, 16'h0600, 1'b1);
    expect_at(2, "t2_pend", 1'b0, -1, 1'b0, 4'b0101);
    expect_at(3, "t2_first", 1'b1, 0, 1'b0, 4'b0101);
    tick(24'h060000);
    step(2);
    expect_at(1, "t2_stop", 1'b0, 0, 1'b0, 4'b0100);
    expect_at(2, "t2_second", 1'b1, 2, 1'b0, 4'b0100);
    pulse(1'b1, 1'b0);
    step(2);
    expect_at(1, "t2_stop2", 1'b0, -1, 1'b0, 4'b0000);
    pulse(1'b1, 1'b0);
    step();

    // Snooze for 300 ticks then re-ring.
    wr(3, 16'h0815, 1'b1);
    expect_at(3, "t3_ring", 1'b1, 3, 1'b0, 4'b1000);
    tick(24'h081500);
    step(2);
    expect_at(1, "t3_snooze", 1'b0, 3, 1'b1, 4'b1000);
    pulse(1'b0, 1'b1);
    fill(299);
    expect_at(1, "t3_snz_last", 1'b0, 3, 1'b1, 4'b1000);
    expect_at(2, "t3_rering", 1'b1, 3, 1'b0, 4'b1000);
    tick(24'h123401);
    step();
    expect_at(1, "t3_stop", 1'b0, -1, 1'b0, 4'b0000);
    pulse(1'b1, 1'b0);
    step();

    // Stop and snooze together: stop wins.
    expect_at(3, "t4_ring", 1'b1, 3, 1'b0, 4'b1000);
    tick(24'h081500);
    step(2);
    expect_at(1, "t4_both", 1'b0, -1, 1'b0, 4'b0000);
    expect_at(2, "t4_stay_idle", 1'b0, -1, 1'b0, 4'b0000);
    pulse(1'b1, 1'b1);
    step(2);

    // Disabled channel never matches.
    wr(1, 16'h0900, 1'b0);
    expect_at(2, "t5_dis_pend", 1'b0, -1, 1'b0, 4'b0000);
    expect_at(3, "t5_dis_ring", 1'b0, -1, 1'b0, 4'b0000);
    tick(24'h090000);
    step();

    // Rewrite of the active channel during snooze.
    wr(0, 16'h0600, 1'b0);
    expect_at(3, "t5_ring2", 1'b1, 2, 1'b0, 4'b0100);
    tick(24'h060000);
    step(2);
    expect_at(1, "t5_snz", 1'b0, 2, 1'b1, 4'b0100);
    pulse(1'b0, 1'b1);
    step(3);
    expect_at(1, "t5_rewrite", 1'b0, -1, 1'b0, 4'b0000);
    expect_at(2, "t5_idle", 1'b0, -1, 1'b0, 4'b0000);
    wr(2, 16'h0600, 1'b1);
    step(2);

    // Asynchronous reset mid-ring clears state and the register file.
    expect_at(3, "t6_ring", 1'b1, 3, 1'b0, 4'b1000);
    tick(24'h081500);
    step(2);
    bus.rd_idx = 2'd3;
    expect_at(0, "t6_rd_pre", 1'b1, 3, 1'b0, 4'b1000, 1);
    step();
    sys_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      expect_at(0, $sformatf("t6_rst_rd%0d", i), 1'b0, 0, 1'b0, 4'b0000, 0);
      step();
    end
    sys_rst_n = 1'b1;
    step(2);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    while (sb.size() > 0) begin
      me = sb.pop_front();
      n_chk++;
      $display("FAIL %s: never sampled, due at cycle %0d", me.name, me.at);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
